// File: rtl/cache_ctrl_pipe_if.sv
// Host/memory bus of the cache command controller.
// slave is the controller side, master is the host/memory side.
interface cache_ctrl_pipe_if #(
   parameter int NUM_ENTRIES = 16,
   parameter int CNT_W       = 16
);
   logic                   op_valid_in;
   logic [1:0]             op_in;
   logic                   op_ready_out;
   logic                   lookup_out;
   logic                   hit;
   logic [NUM_ENTRIES-1:0] idx_in;
   logic [NUM_ENTRIES-1:0] used;
   logic [NUM_ENTRIES-1:0] idx_out;
   logic                   select_out;
   logic                   write_out;
   logic                   delete_out;
   logic                   resp_valid_out;
   logic                   resp_ready_in;
   logic [2:0]             resp_status_out;
   logic                   data_valid_out;
   logic                   clear_stats_in;
   logic [CNT_W-1:0]       hit_cnt_out;
   logic [CNT_W-1:0]       miss_cnt_out;
   logic [1:0]             state_dbg;

   modport slave (
      input  op_valid_in, op_in, hit, idx_in, used, resp_ready_in, clear_stats_in,
      output op_ready_out, lookup_out, idx_out, select_out, write_out, delete_out,
             resp_valid_out, resp_status_out, data_valid_out, hit_cnt_out,
             miss_cnt_out, state_dbg
   );

   modport master (
      output op_valid_in, op_in, hit, idx_in, used, resp_ready_in, clear_stats_in,
      input  op_ready_out, lookup_out, idx_out, select_out, write_out, delete_out,
             resp_valid_out, resp_status_out, data_valid_out, hit_cnt_out,
             miss_cnt_out, state_dbg
   );
endinterface

// File: rtl/cache_ctrl_pipe.sv
// Key/value cache command controller: lookup wait, one strobe per command, held response.
// Define CACHE_CTRL_EVICT_EN to enable round-robin eviction when every entry is used.
module cache_ctrl_pipe #(
   parameter int NUM_ENTRIES = 16,
   parameter int LOOKUP_LAT  = 1,
   parameter int CNT_W       = 16
) (
   input logic               clk,
   input logic               rst_n,
   cache_ctrl_pipe_if.slave  bus
);
   // Handshakes: a command transfers on a cycle with op_valid_in && op_ready_out;
   // a response transfers on a cycle with resp_valid_out && resp_ready_in, and
   // status/data_valid are held stable while resp_valid_out waits for ready.
   localparam int LW = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;
   localparam logic [NUM_ENTRIES-1:0] ONE = NUM_ENTRIES'(1);

   localparam logic [1:0] OP_READ   = 2'd1;
   localparam logic [1:0] OP_UPSERT = 2'd2;
   localparam logic [1:0] OP_DELETE = 2'd3;

   localparam logic [2:0] ST_OK      = 3'd0;
   localparam logic [2:0] ST_MISS    = 3'd1;
   localparam logic [2:0] ST_FULL    = 3'd2;
   localparam logic [2:0] ST_EVICTED = 3'd3;
   localparam logic [2:0] ST_ERR     = 3'd4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      EXEC   = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t                 state, state_nxt;
   logic [1:0]             op_q;
   logic [LW-1:0]          lat_cnt;
   logic                   hit_q;
   logic [NUM_ENTRIES-1:0] idx_q;
   logic [NUM_ENTRIES-1:0] used_q;
   logic [2:0]             status_q;
   logic                   dv_q;
   logic                   ready_q;
   logic [CNT_W-1:0]       hit_cnt;
   logic [CNT_W-1:0]       miss_cnt;

   logic [2:0]             status_d;
   logic                   dv_d;
   logic                   sel_d, wr_d, del_d;
   logic [NUM_ENTRIES-1:0] idx_d;
   logic                   hit_inc, miss_inc;
   logic                   evict_d;

   logic                   idx_onehot;
   logic                   full;
   logic [NUM_ENTRIES-1:0] free_slot;

   assign idx_onehot = (idx_q != '0) && ((idx_q & (idx_q - ONE)) == '0);
   assign full       = &used_q;
   // Adding one ripples through the trailing ones, leaving only the lowest zero set.
   assign free_slot  = ~used_q & (used_q + ONE);

`ifdef CACHE_CTRL_EVICT_EN
   localparam int VW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
   logic [VW-1:0]          victim;
   logic [NUM_ENTRIES-1:0] victim_oh;
   assign victim_oh = ONE << victim;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         victim <= '0;
      end else if (evict_d) begin
         victim <= (victim == VW'(NUM_ENTRIES - 1)) ? '0 : victim + VW'(1);
      end
   end
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.op_valid_in && bus.op_in != 2'd0) state_nxt = LOOKUP;
         LOOKUP:  if (lat_cnt == '0) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (bus.resp_ready_in) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      status_d = ST_OK;
      dv_d     = 1'b0;
      sel_d    = 1'b0;
      wr_d     = 1'b0;
      del_d    = 1'b0;
      idx_d    = '0;
      hit_inc  = 1'b0;
      miss_inc = 1'b0;
      evict_d  = 1'b0;
      if (state == EXEC) begin
         if (hit_q && !idx_onehot) begin
            status_d = ST_ERR;
         end else if (hit_q) begin
            hit_inc = 1'b1;
            idx_d   = idx_q;
            case (op_q)
               OP_READ:   begin sel_d = 1'b1; dv_d = 1'b1; end
               OP_UPSERT: wr_d  = 1'b1;
               OP_DELETE: del_d = 1'b1;
               default:   idx_d = '0;
            endcase
         end else begin
            miss_inc = 1'b1;
            if (op_q != OP_UPSERT) begin
               status_d = ST_MISS;
            end else if (!full) begin
               wr_d  = 1'b1;
               idx_d = free_slot;
            end else begin
`ifdef CACHE_CTRL_EVICT_EN
               wr_d     = 1'b1;
               idx_d    = victim_oh;
               status_d = ST_EVICTED;
               evict_d  = 1'b1;
`else
               status_d = ST_FULL;
`endif
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         op_q     <= '0;
         lat_cnt  <= '0;
         hit_q    <= 1'b0;
         idx_q    <= '0;
         used_q   <= '0;
         status_q <= '0;
         dv_q     <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         ready_q <= (state_nxt == IDLE);
         if (state == IDLE && bus.op_valid_in && bus.op_in != 2'd0) begin
            op_q    <= bus.op_in;
            lat_cnt <= LW'(LOOKUP_LAT - 1);
         end
         if (state == LOOKUP) begin
            if (lat_cnt == '0) begin
               hit_q  <= bus.hit;
               idx_q  <= bus.idx_in;
               used_q <= bus.used;
            end else begin
               lat_cnt <= lat_cnt - LW'(1);
            end
         end
         if (state == EXEC) begin
            status_q <= status_d;
            dv_q     <= dv_d;
         end
      end
   end

   // Clear wins over a same-cycle increment; both counters stick at all ones.
   always_ff @(posedge clk) begin
      if (!rst_n || bus.clear_stats_in) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (hit_inc && hit_cnt != '1)   hit_cnt  <= hit_cnt + CNT_W'(1);
         if (miss_inc && miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
      end
   end

   assign bus.op_ready_out    = ready_q;
   assign bus.lookup_out      = (state == LOOKUP);
   assign bus.select_out      = sel_d;
   assign bus.write_out       = wr_d;
   assign bus.delete_out      = del_d;
   assign bus.idx_out         = idx_d;
   assign bus.resp_valid_out  = (state == RESP);
   assign bus.resp_status_out = (state == RESP) ? status_q : 3'd0;
   assign bus.data_valid_out  = (state == RESP) && dv_q;
   assign bus.hit_cnt_out     = hit_cnt;
   assign bus.miss_cnt_out    = miss_cnt;
   assign bus.state_dbg       = state;
endmodule

// File: tb/tb_cache_ctrl_pipe.sv
// Directed bench for cache_ctrl_pipe with a strobe/response scoreboard.
// Expectations follow CACHE_CTRL_EVICT_EN when it is defined for the build.
module tb_cache_ctrl_pipe;
   localparam int N   = 16;
   localparam int LAT = 2;
   localparam int CW  = 4;

   localparam logic [1:0] OP_NOOP   = 2'd0;
   localparam logic [1:0] OP_READ   = 2'd1;
   localparam logic [1:0] OP_UPSERT = 2'd2;
   localparam logic [1:0] OP_DELETE = 2'd3;

   localparam logic [2:0] S_OK      = 3'd0;
   localparam logic [2:0] S_MISS    = 3'd1;
   localparam logic [2:0] S_FULL    = 3'd2;
   localparam logic [2:0] S_EVICTED = 3'd3;
   localparam logic [2:0] S_ERR     = 3'd4;

   localparam logic [18:0] NO_STROBE = 19'd0;

   // Clock/reset block
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   cache_ctrl_pipe_if #(.NUM_ENTRIES(N), .CNT_W(CW)) bus ();

   cache_ctrl_pipe #(.NUM_ENTRIES(N), .LOOKUP_LAT(LAT), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int cmp_cnt = 0;
   int err_cnt = 0;
   int exp_hit = 0;
   int exp_miss = 0;

   logic [18:0] exp_strobe_q[$];
   logic [3:0]  exp_resp_q[$];
   logic [18:0] mon_strobe;
   logic [3:0]  mon_resp;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [18:0] sel_s(input logic [15:0] i);
      return {3'b100, i};
   endfunction
   function automatic logic [18:0] wr_s(input logic [15:0] i);
      return {3'b010, i};
   endfunction
   function automatic logic [18:0] del_s(input logic [15:0] i);
      return {3'b001, i};
   endfunction

   // Scoreboard monitor: any strobe or response handshake pops one expectation
   always @(negedge clk) begin
      mon_strobe = {bus.select_out, bus.write_out, bus.delete_out, bus.idx_out};
      if (mon_strobe != 19'd0) begin
         if (exp_strobe_q.size() == 0) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL strobe_unexpected: got 0x%0h, expected none", mon_strobe);
         end else begin
            chk("strobe", 32'(mon_strobe), 32'(exp_strobe_q.pop_front()));
         end
      end
      if (bus.resp_valid_out && bus.resp_ready_in) begin
         mon_resp = {bus.resp_status_out, bus.data_valid_out};
         if (exp_resp_q.size() == 0) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL resp_unexpected: got 0x%0h, expected none", mon_resp);
         end else begin
            chk("resp_status_dv", 32'(mon_resp), 32'(exp_resp_q.pop_front()));
         end
      end
   end

   // Driver: one full command; memory inputs are held for the whole command
   task automatic send(input logic [1:0] op, input logic h, input logic [15:0] idx,
                       input logic [15:0] used_v, input logic [2:0] st, input logic dv,
                       input logic [18:0] strobe, input int rdelay, input logic clr);
      int n;
      int lk;
      if (strobe != NO_STROBE) exp_strobe_q.push_back(strobe);
      exp_resp_q.push_back({st, dv});
      n = 0;
      while (!bus.op_ready_out && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("op_ready_wait", 32'(n < 20), 32'd1);
      bus.op_valid_in    = 1'b1;
      bus.op_in          = op;
      bus.hit            = h;
      bus.idx_in         = idx;
      bus.used           = used_v;
      bus.clear_stats_in = clr;
      @(posedge clk); #1;
      bus.op_valid_in = 1'b0;
      n  = 0;
      lk = 0;
      while (!bus.resp_valid_out && n < 30) begin
         if (bus.lookup_out) lk++;
         chk("op_ready_busy", 32'(bus.op_ready_out), 32'd0);
         @(posedge clk); #1;
         n++;
      end
      chk("lookup_cycles", 32'(lk), 32'(LAT));
      chk("resp_latency", 32'(n), 32'(LAT + 1));
      for (int i = 0; i < rdelay; i++) begin
         chk("bp_valid", 32'(bus.resp_valid_out), 32'd1);
         chk("bp_status", 32'(bus.resp_status_out), 32'(st));
         chk("bp_op_ready", 32'(bus.op_ready_out), 32'd0);
         @(posedge clk); #1;
      end
      bus.resp_ready_in = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready_in  = 1'b0;
      bus.clear_stats_in = 1'b0;
      if (clr) begin
         exp_hit  = 0;
         exp_miss = 0;
      end else if (st != S_ERR) begin
         if (h) begin
            if (exp_hit != 15) exp_hit++;
         end else if (exp_miss != 15) begin
            exp_miss++;
         end
      end
      chk("hit_cnt", 32'(bus.hit_cnt_out), 32'(exp_hit));
      chk("miss_cnt", 32'(bus.miss_cnt_out), 32'(exp_miss));
      chk("resp_dropped", 32'(bus.resp_valid_out), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n              = 1'b0;
      bus.op_valid_in    = 1'b1;
      bus.op_in          = OP_READ;
      bus.hit            = 1'b1;
      bus.idx_in         = 16'h0001;
      bus.used           = 16'h0000;
      bus.resp_ready_in  = 1'b0;
      bus.clear_stats_in = 1'b0;

      // Reset held 3 cycles with a command offered
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", 32'({bus.op_ready_out, bus.lookup_out, bus.select_out,
                               bus.write_out, bus.delete_out, bus.resp_valid_out,
                               bus.resp_status_out, bus.data_valid_out}), 32'd0);
      chk("reset_idx_out", 32'(bus.idx_out), 32'd0);
      chk("reset_counters", 32'({bus.hit_cnt_out, bus.miss_cnt_out}), 32'd0);
      chk("reset_state", 32'(bus.state_dbg), 32'd0);
      rst_n           = 1'b1;
      bus.op_valid_in = 1'b0;
      chk("ready_before_edge", 32'(bus.op_ready_out), 32'd0);
      @(posedge clk); #1;
      chk("ready_after_release", 32'(bus.op_ready_out), 32'd1);

      // Main function
      send(OP_READ,   1'b1, 16'h0008, 16'h00FF, S_OK,   1'b1, sel_s(16'h0008), 0, 1'b0);
      send(OP_UPSERT, 1'b0, 16'h0000, 16'h00FF, S_OK,   1'b0, wr_s(16'h0100),  0, 1'b0);
`ifdef CACHE_CTRL_EVICT_EN
      send(OP_UPSERT, 1'b0, 16'h0000, 16'hFFFF, S_EVICTED, 1'b0, wr_s(16'h0001), 0, 1'b0);
      send(OP_UPSERT, 1'b0, 16'h0000, 16'hFFFF, S_EVICTED, 1'b0, wr_s(16'h0002), 0, 1'b0);
      send(OP_UPSERT, 1'b0, 16'h0000, 16'hFFFF, S_EVICTED, 1'b0, wr_s(16'h0004), 0, 1'b0);
`else
      for (int i = 0; i < 3; i++)
         send(OP_UPSERT, 1'b0, 16'h0000, 16'hFFFF, S_FULL, 1'b0, NO_STROBE, 0, 1'b0);
`endif
      send(OP_DELETE, 1'b1, 16'h0006, 16'hFFFF, S_ERR,  1'b0, NO_STROBE,       0, 1'b0);
      send(OP_READ,   1'b1, 16'h0000, 16'hFFFF, S_ERR,  1'b0, NO_STROBE,       0, 1'b0);
      send(OP_DELETE, 1'b1, 16'h0010, 16'hFFFF, S_OK,   1'b0, del_s(16'h0010), 0, 1'b0);
      send(OP_READ,   1'b0, 16'h0000, 16'h0F0F, S_MISS, 1'b0, NO_STROBE,       0, 1'b0);
      send(OP_DELETE, 1'b0, 16'h0000, 16'h0F0F, S_MISS, 1'b0, NO_STROBE,       0, 1'b0);
      send(OP_UPSERT, 1'b1, 16'h8000, 16'hFFFF, S_OK,   1'b0, wr_s(16'h8000),  0, 1'b0);
      send(OP_UPSERT, 1'b0, 16'h0000, 16'hFFFE, S_OK,   1'b0, wr_s(16'h0001),  0, 1'b0);
      send(OP_UPSERT, 1'b0, 16'h0000, 16'h7FFF, S_OK,   1'b0, wr_s(16'h8000),  0, 1'b0);

      // Response backpressure
      send(OP_READ,   1'b1, 16'h0001, 16'h0001, S_OK,   1'b1, sel_s(16'h0001), 5, 1'b0);

      // NOOP is consumed without leaving IDLE
      bus.op_valid_in = 1'b1;
      bus.op_in       = OP_NOOP;
      @(posedge clk); #1;
      bus.op_valid_in = 1'b0;
      chk("noop_ready", 32'(bus.op_ready_out), 32'd1);
      chk("noop_no_lookup", 32'(bus.lookup_out), 32'd0);
      @(posedge clk); #1;

      // Hit counter saturation at 15
      for (int i = 0; i < 12; i++)
         send(OP_READ, 1'b1, 16'h0400, 16'hFFFF, S_OK, 1'b1, sel_s(16'h0400), 0, 1'b0);

      // Clear coinciding with a hit
      send(OP_READ, 1'b1, 16'h0020, 16'hFFFF, S_OK, 1'b1, sel_s(16'h0020), 0, 1'b1);
      send(OP_READ, 1'b0, 16'h0000, 16'hFFFF, S_MISS, 1'b0, NO_STROBE, 0, 1'b0);

      // Reset during LOOKUP drops the command
      bus.op_valid_in = 1'b1;
      bus.op_in       = OP_READ;
      bus.hit         = 1'b1;
      bus.idx_in      = 16'h0002;
      @(posedge clk); #1;
      bus.op_valid_in = 1'b0;
      chk("midreset_in_lookup", 32'(bus.lookup_out), 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("midreset_lookup", 32'(bus.lookup_out), 32'd0);
      chk("midreset_resp", 32'(bus.resp_valid_out), 32'd0);
      chk("midreset_counters", 32'({bus.hit_cnt_out, bus.miss_cnt_out}), 32'd0);
      rst_n    = 1'b1;
      exp_hit  = 0;
      exp_miss = 0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      chk("midreset_idle", 32'(bus.state_dbg), 32'd0);
      chk("midreset_ready", 32'(bus.op_ready_out), 32'd1);

      // Victim pointer restarts at entry 0 after reset
`ifdef CACHE_CTRL_EVICT_EN
      send(OP_UPSERT, 1'b0, 16'h0000, 16'hFFFF, S_EVICTED, 1'b0, wr_s(16'h0001), 0, 1'b0);
`else
      send(OP_UPSERT, 1'b0, 16'h0000, 16'hFFFF, S_FULL, 1'b0, NO_STROBE, 0, 1'b0);
`endif
      send(OP_READ, 1'b1, 16'h0004, 16'hFFFF, S_OK, 1'b1, sel_s(16'h0004), 2, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      chk("strobe_queue_empty", 32'(exp_strobe_q.size()), 32'd0);
      chk("resp_queue_empty", 32'(exp_resp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end
endmodule
